ex_div: RTL
===========

# ex_div

Iterative multi-cycle divider used by the execute stage for DIV/DIVU. It sits directly downstream of the ID/EX pipeline register, alongside the EX ALU. EX drives the operands and a start request, and holds `stallreq` to ctrl until this block reports ready; the stall freezes ID/EX and the stages before it. The result is written as {HI = remainder, LO = quotient} through the EX→MEM HI/LO write path.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; the result is 2*WIDTH bits.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `signed_div_i` input 1: 1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i` input WIDTH: dividend.
- `opdata2_i` input WIDTH: divisor.
- `start_i` input 1: division requested. EX holds it high until `ready_o` is seen.
- `annul_i` input 1: abort the operation in flight (branch/flush); ignored in END.
- `result_o` output 2*WIDTH: {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
- `ready_o` output 1: `result_o` is valid.

## Operation
- State machine with four states: FREE, BYZERO, ON, END.
- Registered internals: 6-bit counter `cnt`, working register `dividend[2*WIDTH:0]`, divisor magnitude, latched operand signs and `signed_div_i`.
- FREE
  - `ready_o` = 0 and `result_o` = 0.
  - If `start_i` = 1 and `annul_i` = 0 and divisor = 0 → BYZERO.
  - If `start_i` = 1 and `annul_i` = 0 and divisor ≠ 0 → ON.
    - `cnt` ← 0.
    - Operands are latched as magnitudes (two's-complement negate when signed and MSB = 1).
    - `dividend` ← {WIDTH'b0, |op1|, 1'b0}.
- BYZERO: `dividend` ← 0 → END. The result is all zeros; no exception is raised.
- ON
  - If `annul_i` = 1 → FREE, `cnt` ← 0.
  - Else if `cnt` < WIDTH, perform one restoring step:
    - t = {1'b0, `dividend`[2W-1:W]} − {1'b0, |op2|}, computed at WIDTH+1 bits.
    - If t[W] = 1: `dividend` ← {`dividend`[2W-1:0], 0}.
    - Else: `dividend` ← {t[W-1:0], `dividend`[W-1:0], 1}.
    - `cnt` increments.
  - Else (`cnt` = WIDTH), sign fix-up, then → END with `cnt` ← 0:
    - Negate the quotient `dividend`[W-1:0] if signed and sign(op1) ≠ sign(op2).
    - Negate the remainder `dividend`[2W:W+1] if signed and op1 < 0.
- END
  - `result_o` ← {`dividend`[2W:W+1], `dividend`[W-1:0]} and `ready_o` ← 1.
  - If `start_i` = 0 → FREE, with `ready_o` ← 0 and `result_o` ← 0.
- Width rules and edge cases:
  - All negation is modulo 2^WIDTH.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (MIPS leaves this undefined; we fix this value).
- Operands are sampled only in FREE. Input changes during ON or END are ignored.

## Timing
- Reset: state FREE, `cnt` = 0, `dividend` = 0, `result_o` = 0, `ready_o` = 0. A reset mid-operation discards all progress.
- Let edge 0 be the edge at which `start_i` is sampled high in FREE. Then:
  - Edges 1..W perform the W iterations.
  - Edge W+1 applies the sign fix-up and enters END.
  - `ready_o` is 1 after edge W+2, i.e. 34 cycles for W = 32.
- Divide by zero: BYZERO after edge 0, END after edge 1, `ready_o` = 1 after edge 2.
- `ready_o` and `result_o` stay stable while `start_i` remains high in END.
- EX drops `start_i` the cycle after sampling `ready_o`. `ready_o` returns to 0 on the next edge.
- Back-to-back divisions need one FREE cycle between them.
- `annul_i` in ON aborts at the next edge; `ready_o` is never asserted for that operation.

## Structure
- Shared defines header (`defines.v`) holds:
  - State codes `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2 bits).
  - `DivResultReady` / `DivResultNotReady`.
  - `DivStart` / `DivStop`.
  - The `EXE_DIV_OP` / `EXE_DIVU_OP` aluop codes decoded by EX to form `start_i` and `signed_div_i`.
- Single flat module; no sub-module. The step subtractor is an inline WIDTH+1-bit expression.

## Test plan
- DIVU 7 / 2, `start_i` held high → `ready_o` after edge 34; `result_o` = {0x00000001, 0x00000003}.
- DIV −7 (0xFFFFFFF9) / 2 → `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- DIVU 5 / 0 → `ready_o` after edge 2, `result_o` = 0. Dropping `start_i` → `ready_o` = 0 and `result_o` = 0 next cycle.
- Abort mid-operation:
  - `annul_i` pulsed at iteration 10 → FREE; `ready_o` stays 0.
  - A new DIVU 100 / 7 started immediately after → {2, 14} with full latency.
- `rst` asserted at iteration 20 → all outputs 0 next cycle. A fresh DIVU 9 / 3 after release → {0, 3}.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared definitions for the iterative divider: FSM state codes, handshake levels
// and the EX aluop codes that select DIV/DIVU.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div.sv
// Restoring multi-cycle divider for DIV/DIVU in EX; result is {remainder, quotient}.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   DivFree   | idle, outputs zero, samples operands on an unannulled start
//   DivByZero | divisor was zero, clears the working register
//   DivOn     | one restoring step per cycle, then sign fix-up
//   DivEnd    | presents the result until EX drops start_i
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = 32  // cnt is 6 bits, so WIDTH must stay below 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam logic [5:0] CNT_LAST = 6'(WIDTH);

  div_state_e           state_q, state_d;
  logic [5:0]           cnt_q;
  logic [2*WIDTH:0]     dividend_q;
  logic [WIDTH-1:0]     divisor_q;
  logic                 signed_q;
  logic                 op1_sign_q;
  logic                 op2_sign_q;
  logic                 ready_q, ready_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 req;
  logic                 divisor_zero;
  logic [WIDTH-1:0]     op1_mag;
  logic [WIDTH-1:0]     op2_mag;
  logic [WIDTH:0]       step_diff;
  logic                 step_done;
  logic [WIDTH-1:0]     quot_raw;
  logic [WIDTH-1:0]     rem_raw;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign req          = (start_i == DivStart) && !annul_i;
  assign divisor_zero = (opdata2_i == '0);
  assign op1_mag      = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign op2_mag      = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

  // Trial subtraction of the divisor from the current partial remainder; bit WIDTH is the borrow.
  assign step_diff = {1'b0, dividend_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};
  assign step_done = (cnt_q == CNT_LAST);

  assign quot_raw = dividend_q[WIDTH-1:0];
  assign rem_raw  = dividend_q[2*WIDTH:WIDTH+1];
  assign quot_fix = (signed_q && (op1_sign_q != op2_sign_q)) ? (~quot_raw + WIDTH'(1)) : quot_raw;
  assign rem_fix  = (signed_q && op1_sign_q) ? (~rem_raw + WIDTH'(1)) : rem_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DivFree;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DivFree: begin
        if (req) begin
          state_d = divisor_zero ? DivByZero : DivOn;
        end
      end
      DivByZero: state_d = DivEnd;
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else if (step_done) begin
          state_d = DivEnd;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_d = DivFree;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  // Outputs are registered: the next-cycle value is formed here and captured below.
  always_comb begin
    ready_d  = DivResultNotReady;
    result_d = '0;
    if (state_q == DivEnd && start_i == DivStart) begin
      ready_d  = DivResultReady;
      result_d = {rem_raw, quot_raw};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      signed_q   <= 1'b0;
      op1_sign_q <= 1'b0;
      op2_sign_q <= 1'b0;
      ready_q    <= DivResultNotReady;
      result_q   <= '0;
    end else begin
      ready_q  <= ready_d;
      result_q <= result_d;
      case (state_q)
        DivFree: begin
          if (req && !divisor_zero) begin
            cnt_q      <= '0;
            divisor_q  <= op2_mag;
            signed_q   <= signed_div_i;
            op1_sign_q <= opdata1_i[WIDTH-1];
            op2_sign_q <= opdata2_i[WIDTH-1];
            dividend_q <= {{WIDTH{1'b0}}, op1_mag, 1'b0};
          end
        end
        DivByZero: begin
          dividend_q <= '0;
        end
        DivOn: begin
          if (annul_i) begin
            cnt_q <= '0;
          end else if (!step_done) begin
            if (step_diff[WIDTH]) begin
              dividend_q <= {dividend_q[2*WIDTH-1:0], 1'b0};
            end else begin
              dividend_q <= {step_diff[WIDTH-1:0], dividend_q[WIDTH-1:0], 1'b1};
            end
            cnt_q <= cnt_q + 6'd1;
          end else begin
            dividend_q[WIDTH-1:0]         <= quot_fix;
            dividend_q[2*WIDTH:WIDTH+1]   <= rem_fix;
            cnt_q                         <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule
